pdp_rdma_nan_filter: RTL
========================

# pdp_rdma_nan_filter

Pipeline stage directly downstream of the PDP read-DMA egress. It consumes the `pdp_rdma2dp` beat stream and detects FP16 NaN lanes, optionally flushing them to zero. It counts NaN elements per layer, tracks layer completion through a three-state controller, and forwards beats at full throughput to the pooling datapath through a registered two-entry skid buffer.

## Interface
- `BWPE`, default 16: bits per element; must be 16 for FP16 NaN detection.
- `THROUGHPUT`, default 4: elements per beat.
- `DW`: derived, equal to BWPE*THROUGHPUT, the data field width.
- `nvdla_core_clk`  in  1: core clock. One clock domain only.
- `nvdla_core_rstn`  in  1: reset, asynchronous, active-low.
- `reg2dp_op_en`  in  1: layer enable, level. A rising edge starts a layer.
- `reg2dp_input_data`  in  2: precision. 2'd2 means FP16; any other value disables NaN detection.
- `reg2dp_nan_to_zero`  in  1: when 1, NaN lanes are replaced with 16'h0000.
- `pdp_rdma2dp_valid`  in  1: input beat valid.
- `pdp_rdma2dp_ready`  out  1: input beat ready.
- `pdp_rdma2dp_pd`  in  DW+12: bits [DW-1:0] are data, lane i at [16i+15:16i]. Bits [DW+11:DW] are the tag. Tag bit 11 is layer_end; the other tag bits pass through unchanged.
- `nan2dp_valid`  out  1: output beat valid.
- `nan2dp_ready`  in  1: output beat ready.
- `nan2dp_pd`  out  DW+12: output beat, same format as the input.
- `dp2reg_nan_input_num`  out  32: NaN lane count of the last completed layer.
- `dp2reg_done`  out  1: one-cycle pulse at layer completion.
- `busy`  out  1: high while the state is not IDLE.

## Operation
- NaN lane test: bits [14:10]==5'h1F and bits [9:0]!=0. The test applies only when `reg2dp_input_data`==2. Infinity (mantissa 0) is not NaN.
- Flush: when `reg2dp_nan_to_zero`=1, a NaN lane becomes 16'h0000. Sign and tag are not retained for a flushed lane. Non-NaN lanes are never modified.
- Counter: `nan_cnt` is 32 bits. On each accepted input beat it adds popcount(NaN lanes), range 0..THROUGHPUT. It saturates at 32'hFFFF_FFFF and never wraps.
- State machine:
  - IDLE: `pdp_rdma2dp_ready`=0. On an `reg2dp_op_en` rising edge (compared with a 1-cycle registered copy), go to RUN and clear `nan_cnt` to 0.
  - RUN: accept beats. When an accepted beat has layer_end=1, go to DRAIN. That beat is counted and forwarded.
  - DRAIN: `pdp_rdma2dp_ready`=0. When the skid buffer is empty, pulse `dp2reg_done` for 1 cycle, load `dp2reg_nan_input_num` with `nan_cnt`, and go to IDLE.
- Skid buffer: two entries holding post-flush pd.
  - `pdp_rdma2dp_ready` = (state==RUN) && (occupancy<2).
  - Ready is computed from registered occupancy only; it has no combinational path from `nan2dp_ready`.
  - `nan2dp_valid` = (occupancy>0), driven from the head register.
- Order is preserved. No beat is dropped or duplicated.
- Counter update and done:
  - A beat accepted in the same cycle that other beats leave updates the counter normally.
  - An op_en rising edge seen outside IDLE is ignored.
  - When a beat has layer_end=1 and adds NaNs, those NaNs are included in the latched value.
- `reg2dp_input_data` and `reg2dp_nan_to_zero` are static while `busy`=1.

## Timing
- Reset values: `pdp_rdma2dp_ready`=0, `nan2dp_valid`=0, `nan2dp_pd`=0, `dp2reg_nan_input_num`=0, `dp2reg_done`=0, `busy`=0, state=IDLE, occupancy=0, `nan_cnt`=0.
- Start: an op_en rising edge sampled at cycle N gives state RUN at cycle N+1. `busy` and `pdp_rdma2dp_ready` are high from N+1.
- Latency: an input accepted at cycle N appears on `nan2dp_valid` at N+1 when the buffer was empty.
- Throughput: 1 beat/cycle sustained while `nan2dp_ready`=1.
- Full buffer: with occupancy 2 and `nan2dp_ready`=0, ready is low from the next cycle. The buffer holds its contents stably; `nan2dp_pd` does not change while valid is high and ready is low.
- Done: the last beat leaves at cycle M, giving occupancy 0 at M+1. `dp2reg_done` is high at M+1 only, `dp2reg_nan_input_num` is updated at M+1, and `busy` is 0 at M+2.
- Reset mid-operation: asynchronous reset clears state and buffer immediately. Buffered beats are discarded and no done pulse is produced.

## Test plan
1. FP16, flush off, 8 beats. Beat 3 has lanes {7E01, 3C00, FC00, 7C00}; last beat has layer_end=1. Required: output data identical to input, `dp2reg_nan_input_num`=1, exactly one `dp2reg_done` pulse, and 7C00/FC00 are not counted.
2. FP16, flush on, all lanes 7FFF over 4 beats. Required: every output lane is 0000, tags are unchanged, count=16.
3. INT8 (`reg2dp_input_data`=0) with the same NaN patterns. Required: count=0 and no lane is modified.
4. Random `nan2dp_ready`, 1000 beats. Required: output equals the input sequence exactly, no overflow, and ready never rises while occupancy is 2.
5. `nan_cnt` forced to 32'hFFFF_FFFE, then 1 beat with 4 NaN lanes. Required: final count 32'hFFFF_FFFF.
6. Reset asserted in RUN with occupancy 2, then a new op_en edge and a 1-beat layer with 2 NaNs. Required: the stale beats never appear at the output and count=2.

Source files
------------

// File: rtl/pdp_rdma_nan_filter_if.sv
// Valid/ready beat stream between the PDP read-DMA egress and the pooling datapath.
interface pdp_rdma_nan_filter_if #(
  parameter int unsigned PW = 76
) ();
  logic          valid;
  logic          ready;
  logic [PW-1:0] pd;

  modport master (output valid, output pd, input ready);
  modport slave  (input valid, input pd, output ready);
endinterface

// File: rtl/pdp_rdma_nan_filter.sv
// FP16 NaN detector/flusher with per-layer NaN count and a registered two-entry skid buffer.
module pdp_rdma_nan_filter #(
  parameter int unsigned BWPE       = 16,
  parameter int unsigned THROUGHPUT = 4
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         reg2dp_op_en,
  input  logic [1:0]                   reg2dp_input_data,
  input  logic                         reg2dp_nan_to_zero,
  pdp_rdma_nan_filter_if.slave         pdp_rdma2dp,
  pdp_rdma_nan_filter_if.master        nan2dp,
  output logic [31:0]                  dp2reg_nan_input_num,
  output logic                         dp2reg_done,
  output logic                         busy
);

  localparam int unsigned DW     = BWPE * THROUGHPUT;
  localparam int unsigned PW     = DW + 12;
  localparam int unsigned CW     = $clog2(THROUGHPUT + 1);
  localparam int unsigned LE_BIT = DW + 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            op_en_d;
  logic            op_rise;
  logic            is_fp16;
  logic [THROUGHPUT-1:0] nan_mask;
  logic [CW-1:0]   nan_num;
  logic [PW-1:0]   flt_pd;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [1:0]      occ;
  logic [1:0]      next_occ;
  logic            push;
  logic            pop;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            done_next;
  logic [31:0]     nan_cnt;
  logic [32:0]     cnt_sum;
  logic [31:0]     cnt_sat;

  assign op_rise            = reg2dp_op_en & ~op_en_d;
  assign is_fp16            = (reg2dp_input_data == 2'd2);
  assign pdp_rdma2dp.ready  = in_ready_q;
  assign nan2dp.valid       = out_valid_q;
  assign nan2dp.pd          = head_q;

  // Per-lane NaN detection, optional flush to zero, and NaN popcount for the beat.
  always_comb begin
    logic [BWPE-1:0] lane;
    nan_mask = '0;
    nan_num  = '0;
    flt_pd   = pdp_rdma2dp.pd;
    lane     = '0;
    for (int unsigned i = 0; i < THROUGHPUT; i++) begin
      lane        = pdp_rdma2dp.pd[i*BWPE +: BWPE];
      nan_mask[i] = is_fp16 && (lane[14:10] == 5'h1F) && (lane[9:0] != 10'd0);
      if (nan_mask[i] && reg2dp_nan_to_zero) begin
        flt_pd[i*BWPE +: BWPE] = '0;
      end
      nan_num = nan_num + CW'(nan_mask[i]);
    end
  end

  // Saturating accumulate so the layer count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_sum = {1'b0, nan_cnt} + 33'(nan_num);
    cnt_sat = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  // Next state, handshake qualifiers and next buffer occupancy.
  always_comb begin
    next_state = state;
    push       = pdp_rdma2dp.valid && in_ready_q;
    pop        = out_valid_q && nan2dp.ready;
    next_occ   = 2'(occ + 2'(push) - 2'(pop));
    case (state)
      S_IDLE:  if (op_rise) next_state = S_RUN;
      S_RUN:   if (push && pdp_rdma2dp.pd[LE_BIT]) next_state = S_DRAIN;
      S_DRAIN: if (occ == 2'd0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    done_next = (next_state == S_DRAIN) && (next_occ == 2'd0);
  end

  // State register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered control outputs, occupancy and layer NaN counter.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_d              <= 1'b0;
      occ                  <= 2'd0;
      in_ready_q           <= 1'b0;
      out_valid_q          <= 1'b0;
      busy                 <= 1'b0;
      dp2reg_done          <= 1'b0;
      dp2reg_nan_input_num <= 32'd0;
      nan_cnt              <= 32'd0;
    end else begin
      op_en_d     <= reg2dp_op_en;
      occ         <= next_occ;
      in_ready_q  <= (next_state == S_RUN) && (next_occ < 2'd2);
      out_valid_q <= (next_occ != 2'd0);
      busy        <= (next_state != S_IDLE);
      dp2reg_done <= done_next;
      if (done_next) begin
        dp2reg_nan_input_num <= nan_cnt;
      end
      if ((state == S_IDLE) && op_rise) begin
        nan_cnt <= 32'd0;
      end else if (push) begin
        nan_cnt <= cnt_sat;
      end
    end
  end

  // Two-entry skid buffer: head drives the output, tail absorbs a beat while head stalls.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) head_q <= flt_pd;
        end
        2'd1: begin
          if (push && pop) head_q <= flt_pd;
          else if (push)   tail_q <= flt_pd;
        end
        default: begin
          if (pop) head_q <= tail_q;
        end
      endcase
    end
  end

endmodule
